bcd_score_display: RTL and testbench
====================================

// Module: bcd_score_display
// PURPOSE
//   Parametrised multi-digit decimal (BCD) score counter with integrated active-low 7-segment drive.
//   Next generation of the single-hex-digit counter/decoder pair: counts in decimal across NUM_DIGITS digits.
//   Supports increment, decrement and clear; wrap or saturate at the limits; optional leading-zero blanking.
//   Sits between game-control logic (score events) and the board HEX displays.
// PARAMETERS
//   NUM_DIGITS  2  number of BCD digits (1..6); max count = 10^NUM_DIGITS - 1
//   SATURATE    1  1: hold at max/zero at the limits; 0: wrap (max+1 -> 0, 0-1 -> max)
//   BLANK_LZ    1  1: blank leading zero digits (digit 0 always lit); 0: show all digits
// PORTS
//   Clock     in   1             system clock, all logic on posedge
//   Reset     in   1             synchronous, active-high; clears count and outputs
//   Inc       in   1             add 1 this cycle
//   Dec       in   1             subtract 1 this cycle
//   Clear     in   1             set count to 0 (priority over Inc/Dec)
//   Digits    out  4*NUM_DIGITS  BCD count, digit 0 in [3:0] (least significant)
//   Segments  out  7*NUM_DIGITS  active-low segments {g..a} per digit, digit 0 in [6:0]
//   AtZero    out  1             count == 0
//   AtMax     out  1             every digit == 9
//   Overflow  out  1             one-cycle pulse on a limit event (see below)
// BEHAVIOUR
//   - Reset (sync): Digits=0, Overflow=0, AtZero=1, AtMax=0.
//     Segments: digit0=7'b1000000; other digits 7'b1111111 if BLANK_LZ, else 7'b1000000.
//   - Priority per edge: Reset > Clear > (Inc xor Dec). Inc&Dec together = no change, no Overflow.
//   - Inc: digit-wise BCD add with ripple carry; a digit at 9 becomes 0 and carries.
//     No digit ever holds 10..15.
//   - Dec: digit-wise BCD subtract with borrow; a digit at 0 becomes 9 and borrows.
//   - Limits:
//     Inc at max: SATURATE=1 -> hold; SATURATE=0 -> all digits 0.
//     Dec at zero: SATURATE=1 -> hold; SATURATE=0 -> all digits 9.
//     In every one of these four cases Overflow=1 for exactly the following cycle.
//   - Overflow is registered; it is 0 on every other cycle, including after Clear.
//   - Latency:
//     Digits/AtZero/AtMax are registered and change on the edge that samples Inc/Dec/Clear.
//     Segments are registered from Digits: valid one cycle after Digits (2 edges after the input).
//   - AtZero/AtMax are decoded from the next-state value and registered together with Digits,
//     so they are always coherent with Digits.
//   - Blanking (BLANK_LZ=1): digit k>0 is blank (7'b1111111) iff digits k..NUM_DIGITS-1 are all 0.
//     Digit 0 is never blank. Blanking is computed from the same Digits value the segments decode.
//   - Segment codes per decimal digit, active-low {g..a}:
//     0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//     Any other code (unreachable) = 1111111.
//   - Reset or Clear mid-ripple: no multi-cycle operations exist; every update completes in one edge.
//   - Inputs are level-sampled each cycle. A 3-cycle Inc pulse counts 3.
//     Edge detection is the caller's job.
// STRUCTURE
//   - Shared package (score_pkg): SEG_BLANK=7'b1111111, SEG_ZERO=7'b1000000,
//     BCD digit typedef logic [3:0], seven-segment lookup function seg7_dec(bcd).
//   - Sub-module bcd_digit: one instance per digit, generate loop.
//     Inputs: inc/dec enable, carry/borrow in.
//     Outputs: digit value, carry/borrow out, is_nine, is_zero.
//     Chained LSD->MSD; top level owns limit detection, saturate/wrap override,
//     Overflow, blanking and the segment register.
// TESTING
//   1. Reset, NUM_DIGITS=2, BLANK_LZ=1 -> Digits=8'h00, Segments={1111111,1000000}, AtZero=1.
//   2. Inc held 10 cycles -> Digits=8'h10. Two cycles later Segments={1111001,1000000}.
//      Inc held 89 more cycles -> Digits=8'h99, AtMax=1.
//   3. At 99, Inc, SATURATE=1 -> stays 99, Overflow high exactly 1 cycle.
//      Same with SATURATE=0 -> 00, AtZero=1, Overflow 1 cycle.
//   4. At 00, Dec, SATURATE=0 -> 99 with Overflow pulse.
//      At 20, Dec -> 19 (borrow path).
//   5. At 47, Inc=Dec=1 -> stays 47, no Overflow.
//      Clear with Inc=1 -> 00. Reset with Clear=1 -> 00.
//   6. NUM_DIGITS=4, BLANK_LZ=0, value 0305 ->
//      Segments={1000000,0110000,1000000,0010010}; with BLANK_LZ=1 the MSD is 1111111.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the BCD score display: segment constants, the BCD
// digit type and the active-low {g..a} seven-segment lookup.
package score_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef logic [3:0] bcd_t;

    function automatic logic [6:0] seg7_dec(input bcd_t bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit of the score counter. Carry/borrow out is a pure
// function of the requested direction and the current value, independent of en.
module bcd_digit
    import score_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic en,
    input  logic inc,
    input  logic dec,
    input  logic cin,
    output bcd_t digit,
    output logic cout,
    output logic is_nine,
    output logic is_zero
);

    bcd_t nxt;

    always_comb begin
        nxt  = digit;
        cout = 1'b0;
        if (inc) begin
            cout = cin && (digit == 4'd9);
        end else if (dec) begin
            cout = cin && (digit == 4'd0);
        end

        if (clear) begin
            nxt = '0;
        end else if (en && cin) begin
            if (inc) begin
                nxt = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end else if (dec) begin
                nxt = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            end
        end
    end

    // Flags describe the value being loaded so the top can register them with it.
    assign is_nine = (nxt == 4'd9);
    assign is_zero = (nxt == 4'd0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            digit <= '0;
        end else begin
            digit <= nxt;
        end
    end

endmodule

// File: rtl/bcd_score_display.sv
// Multi-digit BCD score counter with wrap/saturate limits, a one-cycle
// Overflow pulse and registered active-low seven-segment drive.
module bcd_score_display
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SATURATE   = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Inc,
    input  logic                    Dec,
    input  logic                    Clear,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic [7*NUM_DIGITS-1:0] Segments,
    output logic                    AtZero,
    output logic                    AtMax,
    output logic                    Overflow
);

    logic                  inc_req;
    logic                  dec_req;
    logic                  limit;
    logic                  step_en;
    logic                  lead;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] nine;
    logic [NUM_DIGITS-1:0] zero;
    logic [NUM_DIGITS-1:0] blank;
    bcd_t                  cur [NUM_DIGITS];

    assign inc_req  = Inc & ~Dec;
    assign dec_req  = Dec & ~Inc;
    assign carry[0] = 1'b1;

    // A ripple out of the MSD means every digit is at the limit for this direction;
    // wrap falls out of the ripple itself, saturate just freezes the digits.
    assign limit   = carry[NUM_DIGITS];
    assign step_en = !((SATURATE != 0) && limit);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .Clock   (Clock),
            .Reset   (Reset),
            .clear   (Clear),
            .en      (step_en),
            .inc     (inc_req),
            .dec     (dec_req),
            .cin     (carry[k]),
            .digit   (cur[k]),
            .cout    (carry[k+1]),
            .is_nine (nine[k]),
            .is_zero (zero[k])
        );
        assign Digits[4*k +: 4] = cur[k];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            AtZero   <= 1'b1;
            AtMax    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            AtZero   <= &zero;
            AtMax    <= &nine;
            Overflow <= limit & ~Clear;
        end
    end

    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead     = lead & (cur[k] == 4'd0);
            blank[k] = lead && (BLANK_LZ != 0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                Segments[7*k +: 7] <= ((k == 0) || (BLANK_LZ == 0)) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                Segments[7*k +: 7] <= blank[k] ? SEG_BLANK : seg7_dec(cur[k]);
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_display.sv
// Scoreboard bench for bcd_score_display: four configurations share one input
// stream; an integer-count reference model predicts every output.
module tb_bcd_score_display;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Inc   = 1'b0;
    logic Dec   = 1'b0;
    logic Clear = 1'b0;

    always #5 Clock = ~Clock;

    logic [7:0]  dig_a, dig_b;
    logic [15:0] dig_c, dig_d;
    logic [13:0] seg_a, seg_b;
    logic [27:0] seg_c, seg_d;
    logic [3:0]  atz, atm, ovf;

    bcd_score_display #(.NUM_DIGITS(2), .SATURATE(1), .BLANK_LZ(1)) dut_a (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Clear(Clear),
        .Digits(dig_a), .Segments(seg_a), .AtZero(atz[0]), .AtMax(atm[0]), .Overflow(ovf[0]));
    bcd_score_display #(.NUM_DIGITS(2), .SATURATE(0), .BLANK_LZ(0)) dut_b (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Clear(Clear),
        .Digits(dig_b), .Segments(seg_b), .AtZero(atz[1]), .AtMax(atm[1]), .Overflow(ovf[1]));
    bcd_score_display #(.NUM_DIGITS(4), .SATURATE(0), .BLANK_LZ(0)) dut_c (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Clear(Clear),
        .Digits(dig_c), .Segments(seg_c), .AtZero(atz[2]), .AtMax(atm[2]), .Overflow(ovf[2]));
    bcd_score_display #(.NUM_DIGITS(4), .SATURATE(1), .BLANK_LZ(1)) dut_d (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Clear(Clear),
        .Digits(dig_d), .Segments(seg_d), .AtZero(atz[3]), .AtMax(atm[3]), .Overflow(ovf[3]));

    logic [3:0][15:0] act_dig;
    logic [3:0][27:0] act_seg;
    assign act_dig[0] = {8'h00, dig_a};
    assign act_dig[1] = {8'h00, dig_b};
    assign act_dig[2] = dig_c;
    assign act_dig[3] = dig_d;
    assign act_seg[0] = {14'h0, seg_a};
    assign act_seg[1] = {14'h0, seg_b};
    assign act_seg[2] = seg_c;
    assign act_seg[3] = seg_d;

    int ND  [4] = '{2, 2, 4, 4};
    int SAT [4] = '{1, 0, 0, 1};
    int BLZ [4] = '{1, 0, 0, 1};

    logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct packed {
        logic [3:0][15:0] dig;
        logic [3:0][27:0] seg;
        logic [3:0]       z;
        logic [3:0]       m;
        logic [3:0]       o;
    } exp_t;

    exp_t q[$];
    int   cnt [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int pow10(input int n);
        int p = 1;
        for (int j = 0; j < n; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] r = '0;
        int          x = v;
        for (int j = 0; j < n; j++) begin
            r[4*j +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] segs_of(input int v, input int n, input int blz);
        logic [27:0] r = '0;
        for (int j = 0; j < n; j++) begin
            if (blz != 0 && j > 0 && v < pow10(j)) r[7*j +: 7] = 7'b1111111;
            else                                   r[7*j +: 7] = SEGTAB[(v / pow10(j)) % 10];
        end
        return r;
    endfunction

    // One input cycle: apply inputs, advance the model, queue what the edge must produce.
    task automatic drive(input bit r, input bit c, input bit i, input bit d);
        exp_t e;
        int   maxv;
        bit   ov;
        Reset = r; Clear = c; Inc = i; Dec = d;
        for (int k = 0; k < 4; k++) begin
            maxv = pow10(ND[k]) - 1;
            e.seg[k] = r ? segs_of(0, ND[k], BLZ[k]) : segs_of(cnt[k], ND[k], BLZ[k]);
            ov = 1'b0;
            if (r || c) begin
                cnt[k] = 0;
            end else if (i && !d) begin
                if (cnt[k] == maxv) begin
                    ov = 1'b1;
                    if (SAT[k] == 0) cnt[k] = 0;
                end else begin
                    cnt[k] = cnt[k] + 1;
                end
            end else if (d && !i) begin
                if (cnt[k] == 0) begin
                    ov = 1'b1;
                    if (SAT[k] == 0) cnt[k] = maxv;
                end else begin
                    cnt[k] = cnt[k] - 1;
                end
            end
            e.dig[k] = to_bcd(cnt[k], ND[k]);
            e.z[k]   = (cnt[k] == 0);
            e.m[k]   = (cnt[k] == maxv);
            e.o[k]   = ov;
        end
        q.push_back(e);
        @(negedge Clock);
    endtask

    task automatic chk(input string nm, input int k, input logic [27:0] act, input logic [27:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut %0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk("digits",   k, {12'h0, act_dig[k]}, {12'h0, e.dig[k]});
                    chk("segments", k, act_seg[k], e.seg[k]);
                    chk("atzero",   k, {27'h0, atz[k]}, {27'h0, e.z[k]});
                    chk("atmax",    k, {27'h0, atm[k]}, {27'h0, e.m[k]});
                    chk("overflow", k, {27'h0, ovf[k]}, {27'h0, e.o[k]});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int u;
        bit r, c, i, d;
        for (int k = 0; k < 4; k++) cnt[k] = 0;

        repeat (2) drive(1, 0, 0, 0);
        repeat (10) drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        repeat (89) drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (20) drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        repeat (28) drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 1, 1);
        drive(0, 1, 1, 0);
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);

        repeat (305) drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 49) == 0);
            u = int'($urandom_range(0, 99));
            i = (u < 50) || (u >= 80 && u < 88);
            d = (u >= 50 && u < 88);
            drive(r, c, i, d);
        end
        drive(0, 0, 0, 0);
        Inc = 1'b0; Dec = 1'b0; Clear = 1'b0; Reset = 1'b0;
        repeat (3) @(negedge Clock);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
